counter_ticket_arbiter: RTL
===========================

// Module: counter_ticket_arbiter
// PURPOSE
//  Shares one 8-bit Counter between NCLIENT requesters as a ticket dispenser.
//  Grants clients round-robin, sequences the Counter's add/reset inputs, and returns
//  the post-increment value as a unique ticket. Also reports the wrap (carry) event.
//  Sits between client logic and the Counter instance; owns every Counter control pin.
// PARAMETERS
//  NCLIENT  4  number of requesters (2..8)
//  WIDTH    8  Counter / ticket width in bits
// PORTS
//  clock      in   1        system clock; all state changes on its rising edge
//  reset      in   1        synchronous, active-high
//  req        in   NCLIENT  per-client level request; held until matching ack
//  clear      in   1        level; request Counter reset and wrapped-flag clear
//  ack        out  NCLIENT  one-hot, 1-cycle pulse; ticket valid in same cycle
//  ticket     out  WIDTH    Counter value after the granted increment
//  wrapped    out  1        sticky; set when cnt_carry is seen high in REPLY
//  busy       out  1        high in any state other than IDLE
//  cnt_add    out  1        to Counter add; Counter counts on its rising edge
//  cnt_reset  out  1        to Counter reset
//  cnt_value  in   WIDTH    from Counter value_out
//  cnt_carry  in   1        from Counter carry_out
// BEHAVIOUR
//  Reset (reset=1): state=IDLE; ack=0, ticket=0, wrapped=0, busy=0, cnt_add=0;
//   cnt_reset=1 for every cycle reset is high; last_grant=NCLIENT-1 (client 0 first).
//  Reset mid-operation: any in-flight grant is abandoned, no ack issued.
//  FSM states: IDLE, CLEAR, PULSE, SETTLE, REPLY.
//  IDLE: clear=1 -> CLEAR (clear has priority over req).
//   Else any unmasked req -> pick the first requester after last_grant (wrap at
//   NCLIENT-1 -> 0), register grant -> PULSE. Else stay.
//   Mask: in the IDLE cycle directly after REPLY, the just-acked client's req is ignored.
//  CLEAR: cnt_reset=1 for one cycle; wrapped<=0; -> IDLE.
//  PULSE: cnt_add=1 -> SETTLE.
//  SETTLE: cnt_add=0; gives Counter a full low phase -> REPLY.
//  REPLY: ack[grant]=1; ticket=cnt_value; if cnt_carry, wrapped<=1;
//   last_grant<=grant -> IDLE.
//  Latency: req seen in IDLE at cycle n -> ack at cycle n+3; throughput 1 ticket/4 cycles.
//  Every cnt_add high is exactly 1 cycle and is followed by >=1 low cycle.
//  A committed grant always completes, even if the client drops req early.
//  ticket holds its last value between acks; cnt_add/cnt_reset never high together.
//  Ticket arithmetic is modulo 2^WIDTH: the 2^WIDTH-th ticket after a clear is 0,
//   and wrapped=1 from that REPLY onward.
//  clear during PULSE/SETTLE/REPLY is not acted on until the next IDLE.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE/CLEAR/PULSE/SETTLE/REPLY) and
//   default NCLIENT/WIDTH.
//  Sub-module rr_pick: combinational round-robin select (req, mask, last_grant ->
//   grant index + valid); reusable by other arbiters.
//  Top: FSM, grant/last_grant regs, wrapped flag, ticket register.
// TESTING
//  1 reset, req[0]=1 from cycle 0 -> ack[0] at cycle 3, ticket=1, cnt_add high cycle 1 only.
//  2 req=4'b1111 held, each dropped on its ack -> acks 0,1,2,3, tickets 1..4,
//    4 cycles apart.
//  3 clear=1 and req[2]=1 in the same IDLE cycle -> cnt_reset 1 cycle, then ack[2],
//    ticket=1.
//  4 256 back-to-back tickets to client 1 -> 256th ticket=0, wrapped=1;
//    then clear -> wrapped=0.
//  5 reset asserted while in PULSE -> next cycle all outputs at reset values, no ack;
//    after release, req[1] is still high -> served, ticket=1.
//  6 req[3] held continuously, req[0] raised -> grants alternate 3,0,3,0; no client served twice in a row.

Source files
------------

// File: rtl/counter_ticket_arbiter_pkg.sv
// Shared definitions for the counter ticket arbiter.
//   state_t          : FSM state encoding (IDLE, CLEAR, PULSE, SETTLE, REPLY)
//   DEFAULT_NCLIENT  : default number of requesters
//   DEFAULT_WIDTH    : default Counter / ticket width
package counter_ticket_arbiter_pkg;

    localparam int DEFAULT_NCLIENT = 4;
    localparam int DEFAULT_WIDTH   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PULSE  = 3'd2,
        SETTLE = 3'd3,
        REPLY  = 3'd4
    } state_t;

endpackage

// File: rtl/counter_ticket_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req        : per-client request vector
//   mask       : clients to ignore this cycle
//   last_grant : index of the most recently served client
//   grant      : first eligible client strictly after last_grant (wrapping);
//                last_grant itself is considered last
//   valid      : an eligible client exists
module counter_ticket_arbiter_rr_pick
    import counter_ticket_arbiter_pkg::*;
#(
    parameter int NCLIENT = DEFAULT_NCLIENT,
    parameter int IW      = $clog2(NCLIENT)
) (
    input  logic [NCLIENT-1:0] req,
    input  logic [NCLIENT-1:0] mask,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      grant,
    output logic               valid
);

    localparam int unsigned N = NCLIENT;

    int unsigned   cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = 32'(last_grant) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx] && !mask[cand_idx]) begin
                grant = cand_idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_ticket_arbiter.sv
// Ticket dispenser sharing one external Counter between NCLIENT requesters.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req          : per-client level request, held until its ack
//   clear        : level request to reset the Counter and the wrapped flag
//   ack          : one-hot single-cycle grant acknowledge; ticket valid with it
//   ticket       : Counter value after the granted increment (held between acks)
//   wrapped      : sticky, set when the Counter carry is seen on a reply
//   busy         : FSM is outside IDLE
//   cnt_add      : Counter add strobe (one cycle high, then at least one low)
//   cnt_reset    : Counter reset
//   cnt_value    : Counter value_out
//   cnt_carry    : Counter carry_out
module counter_ticket_arbiter
    import counter_ticket_arbiter_pkg::*;
#(
    parameter int NCLIENT = DEFAULT_NCLIENT,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NCLIENT-1:0] req,
    input  logic               clear,
    output logic [NCLIENT-1:0] ack,
    output logic [WIDTH-1:0]   ticket,
    output logic               wrapped,
    output logic               busy,
    output logic               cnt_add,
    output logic               cnt_reset,
    input  logic [WIDTH-1:0]   cnt_value,
    input  logic               cnt_carry
);

    localparam int IW = $clog2(NCLIENT);

    state_t              state;
    logic [IW-1:0]       grant;
    logic [IW-1:0]       last_grant;
    logic                mask_en;
    logic                cnt_add_q;
    logic                cnt_reset_q;
    logic [NCLIENT-1:0]  pick_mask;
    logic [IW-1:0]       pick_grant;
    logic                pick_valid;

    // Reset drives the Counter reset directly so it holds for every reset
    // cycle, and suppresses an in-flight add so add/reset never overlap.
    assign cnt_add   = cnt_add_q & ~reset;
    assign cnt_reset = cnt_reset_q | reset;

    // The client acked in the previous cycle is ignored for one IDLE cycle.
    always_comb begin
        pick_mask = '0;
        if (mask_en) begin
            pick_mask[last_grant] = 1'b1;
        end
    end

    counter_ticket_arbiter_rr_pick #(
        .NCLIENT (NCLIENT),
        .IW      (IW)
    ) u_rr_pick (
        .req        (req),
        .mask       (pick_mask),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Outputs are registered: each is assigned on the edge entering the
    // state in which it must be visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ack         <= '0;
            ticket      <= '0;
            wrapped     <= 1'b0;
            busy        <= 1'b0;
            cnt_add_q   <= 1'b0;
            cnt_reset_q <= 1'b0;
            grant       <= '0;
            last_grant  <= IW'(NCLIENT - 1);
            mask_en     <= 1'b0;
        end else begin
            ack         <= '0;
            cnt_add_q   <= 1'b0;
            cnt_reset_q <= 1'b0;
            mask_en     <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state       <= CLEAR;
                        cnt_reset_q <= 1'b1;
                        wrapped     <= 1'b0;
                        busy        <= 1'b1;
                    end else if (pick_valid) begin
                        state     <= PULSE;
                        grant     <= pick_grant;
                        cnt_add_q <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                PULSE: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    // Counter has had a full low phase; its value is stable.
                    state      <= REPLY;
                    ack[grant] <= 1'b1;
                    ticket     <= cnt_value;
                    last_grant <= grant;
                    if (cnt_carry) begin
                        wrapped <= 1'b1;
                    end
                end
                REPLY: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mask_en <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
